axis_hex_led_decoder: RTL and testbench

AXIS_HEX_LED_DECODER -- requirements
Module: axis_hex_led_decoder

---
 rtl/axis_gpio_pkg.sv | 30 +++
 rtl/ascii_hex_nibble.sv | 12 +
 rtl/axis_hex_led_decoder.sv | 137 +++++++++++++
 tb/tb_axis_hex_led_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gpio_pkg.sv
// Shared types and helpers for the AXI-Stream hex text decoder: parser states,
// ASCII constants and the hex-character-to-nibble conversion.
package axis_gpio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_ZERO = 2'd1,
        ST_DIGITS   = 2'd2,
        ST_DROP     = 2'd3
    } dec_state_e;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_X_LO = 8'h78;
    localparam logic [7:0] ASCII_X_UP = 8'h58;

    // Returns {is_hex, nibble}; letters map through their low nibble plus 9.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII byte classifier: flags hex digits and yields their value.
module ascii_hex_nibble
    import axis_gpio_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    assign {is_hex_o, nibble_o} = hex_to_nibble(char_i);

endmodule

// File: rtl/axis_hex_led_decoder.sv
// Parses "0x<hex>" text messages from an AXI-Stream byte stream onto led_out.
// Optional macro AXIS_HEX_LED_DECODER_ERRCNT_EN enables the malformed-message counter.
module axis_hex_led_decoder #(
    parameter int GPIO_WIDTH = 2,
    parameter int MAX_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_axis_data,
    input  logic                  s_axis_valid,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic [GPIO_WIDTH-1:0] led_out,
    output logic                  update,
    output logic [15:0]           err_count
);
    import axis_gpio_pkg::*;

    localparam int ACC_W = 4 * MAX_DIGITS;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    dec_state_e            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GPIO_WIDTH-1:0] led_q, led_d;
    logic                  update_q, update_d;
    logic                  ready_q;
    logic                  err_evt;

    logic                  is_hex;
    logic [3:0]            nibble;
    logic                  hs;
    logic                  is_term;
    logic                  cnt_full;
    logic [ACC_W-1:0]      acc_shift;

    ascii_hex_nibble u_nibble (
        .char_i   (s_axis_data),
        .is_hex_o (is_hex),
        .nibble_o (nibble)
    );

    assign hs        = s_axis_valid & ready_q;
    assign is_term   = (s_axis_data == ASCII_CR) || (s_axis_data == ASCII_LF);
    assign cnt_full  = (cnt_q == CNT_W'(MAX_DIGITS));
    assign acc_shift = (acc_q << 4) | ACC_W'(nibble);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        update_d = 1'b0;
        err_evt  = 1'b0;
        if (hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_data == ASCII_ZERO) state_d = ST_GOT_ZERO;
                end
                ST_GOT_ZERO: begin
                    if (s_axis_data == ASCII_X_LO || s_axis_data == ASCII_X_UP) begin
                        state_d = ST_DIGITS;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (s_axis_data != ASCII_ZERO) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DIGITS: begin
                    if (is_hex && !cnt_full) begin
                        acc_d = acc_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                        // A last flag on a digit acts as the terminator.
                        if (s_axis_last) begin
                            led_d    = GPIO_WIDTH'(acc_shift);
                            update_d = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end else if (is_term && cnt_q != '0) begin
                        led_d    = GPIO_WIDTH'(acc_q);
                        update_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        err_evt = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_axis_data == ASCII_LF) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (s_axis_last) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            led_q    <= '0;
            update_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            update_q <= update_d;
            ready_q  <= 1'b1;
        end
    end

`ifdef AXIS_HEX_LED_DECODER_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (err_evt && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
    assign err_count      = '0;
`endif

    assign s_axis_ready = ready_q;
    assign led_out      = led_q;
    assign update       = update_q;

endmodule

// File: tb/tb_axis_hex_led_decoder.sv
// Bench: three decoder configurations share one randomized byte stream and are
// checked every cycle against a string-based message model.
module tb_axis_hex_led_decoder;

`ifdef AXIS_HEX_LED_DECODER_ERRCNT_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_ZERO = 1;
    localparam int M_DIG  = 2;
    localparam int M_DROP = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       vld;
    logic       last;

    logic       rdy_a, rdy_b, rdy_c;
    logic [1:0] led_a;
    logic [7:0] led_b;
    logic [3:0] led_c;
    logic       upd_a, upd_b, upd_c;
    logic [15:0] err_a, err_b, err_c;

    always #5 clk = ~clk;

    axis_hex_led_decoder #(.GPIO_WIDTH(2), .MAX_DIGITS(8)) u_a (
        .clk(clk), .reset_n(rst_n), .s_axis_data(data), .s_axis_valid(vld),
        .s_axis_last(last), .s_axis_ready(rdy_a), .led_out(led_a),
        .update(upd_a), .err_count(err_a));

    axis_hex_led_decoder #(.GPIO_WIDTH(8), .MAX_DIGITS(2)) u_b (
        .clk(clk), .reset_n(rst_n), .s_axis_data(data), .s_axis_valid(vld),
        .s_axis_last(last), .s_axis_ready(rdy_b), .led_out(led_b),
        .update(upd_b), .err_count(err_b));

    axis_hex_led_decoder #(.GPIO_WIDTH(4), .MAX_DIGITS(8)) u_c (
        .clk(clk), .reset_n(rst_n), .s_axis_data(data), .s_axis_valid(vld),
        .s_axis_last(last), .s_axis_ready(rdy_c), .led_out(led_c),
        .update(upd_c), .err_count(err_c));

    int     gw[3] = '{2, 8, 4};
    int     md[3] = '{8, 2, 8};
    int     mode[3];
    string  digs[3];
    longint exp_led[3];
    bit     exp_upd[3];
    int     exp_err[3];
    bit     exp_rdy;
    bit     last_hs;
    int     updcnt[3];
    int     total = 0;
    int     bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
        return -1;
    endfunction

    function automatic longint digits_value(input string s);
        longint v = 0;
        for (int k = 0; k < s.len(); k++) v = v * 16 + hexval(s[k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mode[i] = M_IDLE; digs[i] = ""; exp_led[i] = 0; exp_upd[i] = 0; exp_err[i] = 0;
        end
        exp_rdy = 0;
    endtask

    task automatic model_commit(input int i);
        exp_led[i] = digits_value(digs[i]) % (64'd1 << gw[i]);
        exp_upd[i] = 1;
        mode[i]    = M_IDLE;
    endtask

    task automatic model_byte(input int i, input logic [7:0] b, input logic l);
        int h;
        bit term;
        h    = hexval(b);
        term = (b == 8'h0D) || (b == 8'h0A);
        case (mode[i])
            M_IDLE: if (b == 8'h30) mode[i] = M_ZERO;
            M_ZERO: begin
                if (b == 8'h78 || b == 8'h58) begin
                    mode[i] = M_DIG; digs[i] = "";
                end else if (b != 8'h30) mode[i] = M_IDLE;
            end
            M_DIG: begin
                if (h >= 0 && digs[i].len() < md[i]) begin
                    digs[i] = $sformatf("%s%c", digs[i], b);
                    if (l) model_commit(i);
                end else if (term && digs[i].len() > 0) begin
                    model_commit(i);
                end else begin
                    if (exp_err[i] < 65535) exp_err[i]++;
                    mode[i] = M_DROP;
                end
            end
            default: if (b == 8'h0A) mode[i] = M_IDLE;
        endcase
        if (l) mode[i] = M_IDLE;
    endtask

    task automatic compare_all();
        logic [63:0] al[3], au[3], ae[3], ar[3];
        al = '{64'(led_a), 64'(led_b), 64'(led_c)};
        au = '{64'(upd_a), 64'(upd_b), 64'(upd_c)};
        ae = '{64'(err_a), 64'(err_b), 64'(err_c)};
        ar = '{64'(rdy_a), 64'(rdy_b), 64'(rdy_c)};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("led[%0d]", i), al[i], 64'(exp_led[i]));
            check($sformatf("update[%0d]", i), au[i], 64'(exp_upd[i]));
            check($sformatf("err_count[%0d]", i), ae[i], 64'(EN * exp_err[i]));
            check($sformatf("ready[%0d]", i), ar[i], 64'(exp_rdy));
            if (au[i] == 64'd1) updcnt[i]++;
        end
    endtask

    // One clock: model consumes the byte seen at the rising edge, outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        last_hs = 0;
        if (rst_n) begin
            last_hs = vld && exp_rdy;
            exp_rdy = 1;
            for (int i = 0; i < 3; i++) begin
                exp_upd[i] = 0;
                if (last_hs) model_byte(i, data, last);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        vld = 0; last = 0; data = 8'h00;
        rst_n = 0;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
        int n;
        vld = 0; last = 0;
        for (int g = 0; g < gap; g++) tick();
        vld = 1; data = b; last = l;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_hs && n < 16);
        if (!last_hs) check("handshake_timeout", 64'd0, 64'd1);
        vld = 0; last = 0;
    endtask

    // term: 0 none, 1 CRLF, 2 LF; the final byte sent carries last when lst is set.
    task automatic send_msg(input string body, input int term, input bit lst, input int gap_max);
        int nb;
        logic [7:0] q[$];
        for (int k = 0; k < body.len(); k++) q.push_back(body[k]);
        if (term == 1) begin q.push_back(8'h0D); q.push_back(8'h0A); end
        if (term == 2) q.push_back(8'h0A);
        nb = q.size();
        for (int k = 0; k < nb; k++)
            send_byte(q[k], lst && (k == nb - 1), $urandom_range(0, gap_max));
        tick();
        tick();
    endtask

    task automatic send_random_msg();
        string junk, hexs;
        logic [7:0] q[$];
        int nd, t;
        bit lst;
        junk = "AZ :!0x5g";
        hexs = "0123456789abcdefABCDEF";
        for (int k = 0; k < $urandom_range(0, 3); k++) q.push_back(junk[$urandom_range(0, junk.len() - 1)]);
        case ($urandom_range(0, 3))
            0: begin q.push_back(8'h30); q.push_back(8'h58); end
            1: begin q.push_back(8'h30); q.push_back(8'h30); q.push_back(8'h78); end
            default: begin q.push_back(8'h30); q.push_back(8'h78); end
        endcase
        nd = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 4);
        for (int k = 0; k < nd; k++) q.push_back(hexs[$urandom_range(0, hexs.len() - 1)]);
        if ($urandom_range(0, 7) == 0) q.push_back(8'h67);
        t = $urandom_range(0, 4);
        case (t)
            0: q.push_back(8'h0D);
            1: q.push_back(8'h0A);
            2: begin q.push_back(8'h0D); q.push_back(8'h0A); end
            3: ;
            default: q.push_back(8'h20);
        endcase
        lst = (t == 3) || ($urandom_range(0, 2) == 0);
        for (int k = 0; k < q.size(); k++)
            send_byte(q[k], lst && (k == q.size() - 1), $urandom_range(0, 2));
    endtask

    initial begin
        int u0[3];
        vld = 0; last = 0; data = 8'h00; rst_n = 1;
        for (int i = 0; i < 3; i++) updcnt[i] = 0;
        @(negedge clk);
        do_reset();
        check("reset_led_a", 64'(led_a), 64'd0);
        check("reset_rdy_a_released", 64'(rdy_a), 64'd0);
        tick();

        u0 = updcnt;
        send_msg("SWITCHES CHANGED! NEW VALUE: 0x3", 1, 1, 0);
        check("switch_msg_led_a", 64'(led_a), 64'd3);
        check("switch_msg_pulses_a", 64'(updcnt[0] - u0[0]), 64'd1);
        check("switch_msg_err_a", 64'(err_a), 64'd0);

        u0 = updcnt;
        send_msg("0x1", 0, 1, 0);
        check("last_digit_led_a", 64'(led_a), 64'd1);
        check("last_digit_pulses_a", 64'(updcnt[0] - u0[0]), 64'd1);

        send_msg("0xG", 1, 0, 0);
        check("bad_digit_led_a", 64'(led_a), 64'd1);
        send_msg("0x2", 1, 0, 0);
        check("after_bad_led_a", 64'(led_a), 64'd2);
        check("after_bad_err_a", 64'(err_a), 64'(EN));

        do_reset();
        tick();
        send_msg("0x5A", 2, 0, 0);
        send_msg("0x1A5", 2, 0, 0);
        check("overflow_led_b", 64'(led_b), 64'h5A);
        check("overflow_err_b", 64'(err_b), 64'(EN));
        check("wide_ok_led_a", 64'(led_a), 64'd1);

        do_reset();
        tick();
        u0 = updcnt;
        send_msg("0x", 0, 0, 0);
        do_reset();
        tick();
        send_msg("1", 1, 0, 0);
        check("midreset_led_a", 64'(led_a), 64'd0);
        check("midreset_err_a", 64'(err_a), 64'd0);
        check("midreset_pulses_a", 64'(updcnt[0] - u0[0]), 64'd0);

        u0 = updcnt;
        send_msg("0xAB", 1, 0, 3);
        check("gaps_led_c", 64'(led_c), 64'hB);
        check("gaps_pulses_c", 64'(updcnt[2] - u0[2]), 64'd1);
        check("gaps_led_b", 64'(led_b), 64'hAB);

        for (int m = 0; m < 120; m++) begin
            if (m == 60) begin
                send_byte(8'h30, 0, 0);
                send_byte(8'h78, 0, 0);
                do_reset();
                tick();
            end
            send_random_msg();
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
